hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 16-bit, 8-register, 5-stage core.
- Sits beside ID and consumes ID's decoded source addresses plus the EX/MEM/WB destination tags.
- Drives ID's stall input and the IF flush.
- Registers the EX-stage operand forwarding selects, and sequences load-use bubbles and external memory wait stalls through a small FSM.

---
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, memory-wait freezes, IF flush, EX forwarding selects.
// Optional HAZARD_PERF_CNT_EN builds saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int REG_AW        = 3,
   parameter int OPC_W         = 4,
   parameter int LD_OPC        = 10,
   parameter int ST_OPC        = 11,
   parameter int IMM_FIRST_OPC = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPC_W-1:0]  id_opcode,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_branch_taken,
   input  logic [REG_AW-1:0] ex_op_dest,
   input  logic              ex_wb_en,
   input  logic              ex_wb_mux,
   input  logic [REG_AW-1:0] mem_op_dest,
   input  logic              mem_wb_en,
   input  logic [REG_AW-1:0] wb_op_dest,
   input  logic              wb_wb_en,
   input  logic              mem_busy,
   output logic              stall,
   output logic              freeze_ex,
   output logic              flush_if,
   output logic [1:0]        fwd_sel1,
   output logic [1:0]        fwd_sel2,
   output logic [15:0]       stall_cycles,
   output logic [15:0]       flush_count
);

   localparam logic [OPC_W-1:0] LP_ST_OPC    = OPC_W'(ST_OPC);
   localparam logic [OPC_W-1:0] LP_LD_OPC    = OPC_W'(LD_OPC);
   localparam logic [OPC_W-1:0] LP_IMM_FIRST = OPC_W'(IMM_FIRST_OPC);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_LDUSE   = 2'd1,
      S_MEMWAIT = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic       w_luh;
   logic       w_stall;
   logic       w_freeze;
   logic       w_flush;
   logic [1:0] w_fwd1;
   logic [1:0] w_fwd2;
   logic [1:0] r_fwd1;
   logic [1:0] r_fwd2;
   logic       w_unused;

   // WB-stage results reach the regfile before ID reads it, so those tags never need a forward.
   assign w_unused = ^{wb_op_dest, wb_wb_en, LP_LD_OPC};

   assign w_uses_rs1 = (id_opcode != '0);
   assign w_uses_rs2 = ((id_opcode != '0) && (id_opcode < LP_IMM_FIRST)) || (id_opcode == LP_ST_OPC);

   assign w_luh = ex_wb_en && ex_wb_mux && (ex_op_dest != '0) &&
                  ((w_uses_rs1 && (ex_op_dest == id_rs1_addr)) ||
                   (w_uses_rs2 && (ex_op_dest == id_rs2_addr)));

   function automatic logic [1:0] fwd_src(
      input logic              used,
      input logic [REG_AW-1:0] src,
      input logic              ex_en,
      input logic              ex_ld,
      input logic [REG_AW-1:0] ex_dst,
      input logic              mem_en,
      input logic [REG_AW-1:0] mem_dst
   );
      logic [1:0] sel;
      sel = 2'd0;
      if (used && (src != '0)) begin
         if (ex_en && !ex_ld && (ex_dst == src)) begin
            sel = 2'd1;
         end else if (mem_en && (mem_dst == src)) begin
            sel = 2'd2;
         end
      end
      return sel;
   endfunction

   assign w_fwd1 = fwd_src(w_uses_rs1, id_rs1_addr, ex_wb_en, ex_wb_mux, ex_op_dest, mem_wb_en, mem_op_dest);
   assign w_fwd2 = fwd_src(w_uses_rs2, id_rs2_addr, ex_wb_en, ex_wb_mux, ex_op_dest, mem_wb_en, mem_op_dest);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_freeze     = 1'b0;
      w_flush      = 1'b0;
      case (r_state)
         S_RUN: begin
            if (mem_busy) begin
               w_stall      = 1'b1;
               w_freeze     = 1'b1;
               w_state_next = S_MEMWAIT;
            end else if (w_luh) begin
               w_stall      = 1'b1;
               w_state_next = S_LDUSE;
            end else if (id_branch_taken) begin
               w_flush      = 1'b1;
            end
         end
         S_LDUSE: begin
            w_state_next = mem_busy ? S_MEMWAIT : S_RUN;
         end
         S_MEMWAIT: begin
            if (mem_busy) begin
               w_stall  = 1'b1;
               w_freeze = 1'b1;
            end else begin
               w_state_next = S_RUN;
            end
         end
         default: begin
            w_state_next = S_RUN;
         end
      endcase
   end

   assign stall     = rst & w_stall;
   assign freeze_ex = rst & w_freeze;
   assign flush_if  = rst & w_flush;

   // A frozen EX stage keeps its instruction, so the selects hold rather than taking the ID bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fwd1 <= 2'd0;
         r_fwd2 <= 2'd0;
      end else if (w_freeze) begin
         r_fwd1 <= r_fwd1;
         r_fwd2 <= r_fwd2;
      end else if (w_stall) begin
         r_fwd1 <= 2'd0;
         r_fwd2 <= 2'd0;
      end else begin
         r_fwd1 <= w_fwd1;
         r_fwd2 <= w_fwd2;
      end
   end

   assign fwd_sel1 = r_fwd1;
   assign fwd_sel2 = r_fwd2;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= 16'd0;
         r_flush_count  <= 16'd0;
      end else begin
         if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
         end
         if (w_flush && (r_flush_count != 16'hFFFF)) begin
            r_flush_count <= r_flush_count + 16'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`else
   assign stall_cycles = 16'd0;
   assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  id_opcode;
   logic [2:0]  id_rs1_addr;
   logic [2:0]  id_rs2_addr;
   logic        id_branch_taken;
   logic [2:0]  ex_op_dest;
   logic        ex_wb_en;
   logic        ex_wb_mux;
   logic [2:0]  mem_op_dest;
   logic        mem_wb_en;
   logic [2:0]  wb_op_dest;
   logic        wb_wb_en;
   logic        mem_busy;
   logic        stall;
   logic        freeze_ex;
   logic        flush_if;
   logic [1:0]  fwd_sel1;
   logic [1:0]  fwd_sel2;
   logic [15:0] stall_cycles;
   logic [15:0] flush_count;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   hazard_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .id_opcode       (id_opcode),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .id_branch_taken (id_branch_taken),
      .ex_op_dest      (ex_op_dest),
      .ex_wb_en        (ex_wb_en),
      .ex_wb_mux       (ex_wb_mux),
      .mem_op_dest     (mem_op_dest),
      .mem_wb_en       (mem_wb_en),
      .wb_op_dest      (wb_op_dest),
      .wb_wb_en        (wb_wb_en),
      .mem_busy        (mem_busy),
      .stall           (stall),
      .freeze_ex       (freeze_ex),
      .flush_if        (flush_if),
      .fwd_sel1        (fwd_sel1),
      .fwd_sel2        (fwd_sel2),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic       br;
      logic [2:0] exd;
      logic       exw;
      logic       exm;
      logic [2:0] memd;
      logic       memw;
      logic [2:0] wbd;
      logic       wbw;
      logic       busy;
      logic       e_stall;
      logic       e_freeze;
      logic       e_flush;
      logic [1:0] e_f1;
      logic [1:0] e_f2;
   } vec_t;

   int n_checks = 0;
   int n_err    = 0;

   vec_t seq_a [6];
   vec_t tbl   [25];
   vec_t v_nop;
   vec_t v_fwd;
   vec_t v_busy;
   vec_t v_luh;
   vec_t v_br;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      id_opcode       = v.op;
      id_rs1_addr     = v.rs1;
      id_rs2_addr     = v.rs2;
      id_branch_taken = v.br;
      ex_op_dest      = v.exd;
      ex_wb_en        = v.exw;
      ex_wb_mux       = v.exm;
      mem_op_dest     = v.memd;
      mem_wb_en       = v.memw;
      wb_op_dest      = v.wbd;
      wb_wb_en        = v.wbw;
      mem_busy        = v.busy;
   endtask

   // Drive one cycle: check combinational outputs before the edge, registered selects after it.
   task automatic step(input string tag, input vec_t v);
      apply(v);
      #1;
      chk({tag, "_stall"},  {15'd0, stall},     {15'd0, v.e_stall});
      chk({tag, "_freeze"}, {15'd0, freeze_ex}, {15'd0, v.e_freeze});
      chk({tag, "_flush"},  {15'd0, flush_if},  {15'd0, v.e_flush});
      @(posedge clk);
      #1;
      chk({tag, "_fwd1"}, {14'd0, fwd_sel1}, {14'd0, v.e_f1});
      chk({tag, "_fwd2"}, {14'd0, fwd_sel2}, {14'd0, v.e_f2});
      $display("vec %s: stall=%0b freeze=%0b flush=%0b fwd=%0d/%0d", tag, stall, freeze_ex, flush_if, fwd_sel1, fwd_sel2);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      //               op rs1 rs2 br exd exw exm memd memw wbd wbw busy st fz fl f1 f2
      v_nop  = '{4'd0,  3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      v_fwd  = '{4'd2,  3'd2, 3'd2, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1};
      v_busy = '{4'd1,  3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1};
      v_luh  = '{4'd1,  3'd5, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
      v_br   = '{4'd12, 3'd2, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};

      // Three busy cycles from RUN with the selects frozen, release, then a taken branch.
      seq_a[0] = v_fwd;
      seq_a[1] = v_busy;
      seq_a[2] = v_busy;
      seq_a[3] = v_busy;
      seq_a[4] = '{4'd1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
      seq_a[5] = v_br;

      tbl[0]  = v_nop;
      tbl[1]  = v_fwd;
      tbl[2]  = '{4'd1,  3'd1, 3'd4, 1'b0, 3'd4, 1'b1, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
      tbl[3]  = '{4'd9,  3'd1, 3'd4, 1'b0, 3'd4, 1'b1, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[4]  = '{4'd1,  3'd5, 3'd6, 1'b0, 3'd3, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
      tbl[5]  = '{4'd1,  3'd7, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[6]  = '{4'd1,  3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[7]  = '{4'd1,  3'd3, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
      tbl[8]  = '{4'd11, 3'd1, 3'd6, 1'b0, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
      tbl[9]  = v_br;
      tbl[10] = '{4'd12, 3'd2, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
      tbl[11] = '{4'd1,  3'd1, 3'd3, 1'b0, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[12] = '{4'd1,  3'd1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
      tbl[13] = v_luh;
      tbl[14] = '{4'd1,  3'd5, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
      tbl[15] = '{4'd11, 3'd1, 3'd4, 1'b0, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[16] = v_nop;
      tbl[17] = '{4'd9,  3'd1, 3'd4, 1'b0, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[18] = '{4'd0,  3'd4, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[19] = '{4'd1,  3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[20] = '{4'd1,  3'd2, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[21] = '{4'd0,  3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
      tbl[22] = '{4'd0,  3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};
      tbl[23] = '{4'd1,  3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
      tbl[24] = v_br;

      // Reset held with a busy memory and a taken branch on the inputs: outputs must stay quiet.
      rst = 1'b0;
      apply(v_nop);
      mem_busy        = 1'b1;
      id_branch_taken = 1'b1;
      #12;
      chk("rst_stall",  {15'd0, stall},     16'd0);
      chk("rst_freeze", {15'd0, freeze_ex}, 16'd0);
      chk("rst_flush",  {15'd0, flush_if},  16'd0);
      chk("rst_fwd1",   {14'd0, fwd_sel1},  16'd0);
      chk("rst_fwd2",   {14'd0, fwd_sel2},  16'd0);
      chk("rst_stall_cycles", stall_cycles, 16'd0);
      chk("rst_flush_count",  flush_count,  16'd0);
      apply(v_nop);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) step($sformatf("seqA%0d", i), seq_a[i]);
      chk("seqA_stall_cycles", stall_cycles, PERF ? 16'd3 : 16'd0);
      chk("seqA_flush_count",  flush_count,  PERF ? 16'd1 : 16'd0);

      for (int i = 0; i < 25; i++) step($sformatf("tbl%0d", i), tbl[i]);

      // Reset pulsed while in LDUSE.
      step("ldr_luh", v_luh);
      rst             = 1'b0;
      mem_busy        = 1'b1;
      id_branch_taken = 1'b1;
      #1;
      chk("ldr_stall",  {15'd0, stall},     16'd0);
      chk("ldr_freeze", {15'd0, freeze_ex}, 16'd0);
      chk("ldr_flush",  {15'd0, flush_if},  16'd0);
      chk("ldr_stall_cycles", stall_cycles, 16'd0);
      chk("ldr_flush_count",  flush_count,  16'd0);
      apply(v_luh);
      mem_busy = 1'b0;
      rst      = 1'b1;
      #1;
      chk("ldr_post_stall", {15'd0, stall}, 16'd1);
      apply(v_nop);
      #1;
      chk("ldr_post_nop_stall", {15'd0, stall}, 16'd0);
      step("ldr_branch", v_br);
      $display("seq reset_in_lduse: done");

      // Reset pulsed while in MEMWAIT with non-zero selects held.
      step("mwr_fwd", v_fwd);
      step("mwr_busy", v_busy);
      rst = 1'b0;
      #1;
      chk("mwr_fwd1",   {14'd0, fwd_sel1},  16'd0);
      chk("mwr_fwd2",   {14'd0, fwd_sel2},  16'd0);
      chk("mwr_stall",  {15'd0, stall},     16'd0);
      chk("mwr_freeze", {15'd0, freeze_ex}, 16'd0);
      apply(v_nop);
      rst = 1'b1;
      #1;
      chk("mwr_post_stall", {15'd0, stall}, 16'd0);
      step("mwr_branch", v_br);
      $display("seq reset_in_memwait: done");

`ifdef HAZARD_PERF_CNT_EN
      rst = 1'b0;
      #1;
      rst      = 1'b1;
      mem_busy = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      chk("sat_stall", {15'd0, stall}, 16'd1);
      chk("sat_stall_cycles", stall_cycles, 16'hFFFF);
      mem_busy = 1'b0;
      @(posedge clk);
      #1;
      chk("sat_hold_stall_cycles", stall_cycles, 16'hFFFF);
      $display("seq saturation: stall_cycles=%0h", stall_cycles);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
